// File: rtl/simon_pkg.sv
// simon_pkg: colour encodings, one-hot LED patterns and sequence player states.
package simon_pkg;
  localparam logic [1:0] COL_RED    = 2'd0;
  localparam logic [1:0] COL_GREEN  = 2'd1;
  localparam logic [1:0] COL_BLUE   = 2'd2;
  localparam logic [1:0] COL_YELLOW = 2'd3;
  localparam logic [3:0] LED_OFF    = 4'b0000;
  localparam logic [3:0] LED_RED    = 4'b0001;
  localparam logic [3:0] LED_GREEN  = 4'b0010;
  localparam logic [3:0] LED_BLUE   = 4'b0100;
  localparam logic [3:0] LED_YELLOW = 4'b1000;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ON, S_OFF, S_DONE} player_state_t;
endpackage

// File: rtl/sequence_player_if.sv
// sequence_player_if: control, ROM read and LED signals of the sequence player (abort with SEQ_PLAYER_ABORT_EN).
interface sequence_player_if #(parameter int AW = 4);
  logic          start;
  logic [AW-1:0] len;
  logic [AW-1:0] rd_addr;
  logic [1:0]    rd_data;
  logic [3:0]    led;
  logic          busy;
  logic          done;
`ifdef SEQ_PLAYER_ABORT_EN
  logic          abort;
  modport master(output start, len, rd_data, abort, input rd_addr, led, busy, done);
  modport slave(input start, len, rd_data, abort, output rd_addr, led, busy, done);
`else
  modport master(output start, len, rd_data, input rd_addr, led, busy, done);
  modport slave(input start, len, rd_data, output rd_addr, led, busy, done);
`endif
endinterface

// File: rtl/led_onehot_encoder.sv
// led_onehot_encoder: maps a 2-bit colour to its one-hot LED pattern.
module led_onehot_encoder
  import simon_pkg::*;
(
  input  logic [1:0] col_i,
  output logic [3:0] led_o
);
  assign led_o = col_i == COL_RED   ? LED_RED :
                 col_i == COL_GREEN ? LED_GREEN :
                 col_i == COL_BLUE  ? LED_BLUE : LED_YELLOW;
endmodule

// File: rtl/sequence_player.sv
// sequence_player: replays the first len ROM colours on the LEDs with timed on/off gaps.
// Define SEQ_PLAYER_ABORT_EN to add the abort input.
module sequence_player
  import simon_pkg::*;
#(
  parameter int N       = 10,
  parameter int AW      = 4,
  parameter int ON_CYC  = 3,
  parameter int OFF_CYC = 1
) (
  input logic clk,
  input logic reset,
  sequence_player_if.slave sp
);
  localparam int TW = $clog2(ON_CYC > OFF_CYC ? ON_CYC : OFF_CYC) + 1;
  player_state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, addr_q, addr_d, len_q, len_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    led_q, led_d, col_led;
  logic          busy_q, busy_d, done_q, done_d, abort_w;
`ifdef SEQ_PLAYER_ABORT_EN
  assign abort_w = sp.abort;
`else
  assign abort_w = 1'b0;
`endif
  led_onehot_encoder u_enc (.col_i(sp.rd_data), .led_o(col_led));
  assign sp.rd_addr = addr_q;
  assign sp.led     = led_q;
  assign sp.busy    = busy_q;
  assign sp.done    = done_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    len_d   = len_q;
    timer_d = timer_q;
    led_d   = led_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (sp.start) begin
        if (sp.len != '0) begin
          len_d   = sp.len > AW'(N) ? AW'(N) : sp.len;
          idx_d   = '0;
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_FETCH: begin
        led_d   = col_led;
        timer_d = TW'(ON_CYC - 1);
        state_d = S_ON;
      end
      S_ON: if (timer_q == '0) begin
        led_d   = LED_OFF;
        timer_d = TW'(OFF_CYC - 1);
        state_d = S_OFF;
      end else timer_d = timer_q - 1'b1;
      S_OFF: if (timer_q != '0) timer_d = timer_q - 1'b1;
      else if (idx_q == len_q - 1'b1) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + 1'b1;
        addr_d  = idx_q + 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_w && state_q != S_IDLE) begin
      state_d = S_IDLE;
      led_d   = LED_OFF;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      timer_q <= '0;
      led_q   <= LED_OFF;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      timer_q <= timer_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: directed checks of playback timing, clamping, ignored starts and reset (abort with SEQ_PLAYER_ABORT_EN).
module tb_sequence_player;
  logic clk = 1'b0, reset = 1'b1;
  int checks = 0, errors = 0;
  logic [1:0] rom [16];
  logic [3:0] led_tab [17] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0,
                               4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0};
  sequence_player_if #(.AW(4)) sif ();
  sequence_player dut (.clk(clk), .reset(reset), .sp(sif));
  always #5 clk = ~clk;
  assign sif.rd_data = rom[sif.rd_addr];

  task automatic pulse_start(input logic [3:0] l);
    @(negedge clk);
    sif.start = 1'b1;
    sif.len = l;
    @(negedge clk);
    sif.start = 1'b0;
    sif.len = 4'd7;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks += 4;
    if (sif.led !== 4'h0) begin errors++; $display("FAIL reset_led got %h exp 0", sif.led); end
    if (sif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", sif.busy); end
    if (sif.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", sif.done); end
    if (sif.rd_addr !== 4'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", sif.rd_addr); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_len3(input string name, input logic second_start);
    pulse_start(4'd3);
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) @(negedge clk);
      checks += 3;
      if (sif.led !== led_tab[k-1]) begin errors++; $display("FAIL %s_led c%0d got %h exp %h", name, k, sif.led, led_tab[k-1]); end
      if (sif.busy !== (k <= 15)) begin errors++; $display("FAIL %s_busy c%0d got %b exp %b", name, k, sif.busy, k <= 15); end
      if (sif.done !== (k == 16)) begin errors++; $display("FAIL %s_done c%0d got %b exp %b", name, k, sif.done, k == 16); end
      if (k == 1 || k == 6 || k == 11) begin
        checks++;
        if (sif.rd_addr !== 4'((k - 1) / 5)) begin errors++; $display("FAIL %s_addr c%0d got %0d exp %0d", name, k, sif.rd_addr, (k - 1) / 5); end
      end
      if (second_start && k == 3) begin sif.start = 1'b1; sif.len = 4'd1; end
      if (k == 4) sif.start = 1'b0;
    end
  endtask

  task automatic test_basic;
    run_len3("basic", 1'b0);
  endtask

  task automatic test_ignored_start;
    run_len3("dblstart", 1'b1);
  endtask

  task automatic test_len_zero;
    pulse_start(4'd0);
    checks += 3;
    if (sif.done !== 1'b1) begin errors++; $display("FAIL len0_done got %b exp 1", sif.done); end
    if (sif.busy !== 1'b0) begin errors++; $display("FAIL len0_busy got %b exp 0", sif.busy); end
    if (sif.led !== 4'h0) begin errors++; $display("FAIL len0_led got %h exp 0", sif.led); end
    @(negedge clk);
    checks += 2;
    if (sif.done !== 1'b0) begin errors++; $display("FAIL len0_done2 got %b exp 0", sif.done); end
    if (sif.led !== 4'h0) begin errors++; $display("FAIL len0_led2 got %h exp 0", sif.led); end
  endtask

  task automatic test_clamp;
    logic [3:0] one = 4'b0001;
    logic [3:0] exp_led;
    int max_addr = 0;
    pulse_start(4'd15);
    for (int k = 1; k <= 52; k++) begin
      if (k > 1) @(negedge clk);
      exp_led = (k <= 50 && (k - 1) % 5 >= 1 && (k - 1) % 5 <= 3) ? one << rom[(k - 1) / 5] : 4'h0;
      if (int'(sif.rd_addr) > max_addr) max_addr = int'(sif.rd_addr);
      checks += 3;
      if (sif.led !== exp_led) begin errors++; $display("FAIL clamp_led c%0d got %h exp %h", k, sif.led, exp_led); end
      if (sif.busy !== (k <= 50)) begin errors++; $display("FAIL clamp_busy c%0d got %b exp %b", k, sif.busy, k <= 50); end
      if (sif.done !== (k == 51)) begin errors++; $display("FAIL clamp_done c%0d got %b exp %b", k, sif.done, k == 51); end
    end
    checks++;
    if (max_addr != 9) begin errors++; $display("FAIL clamp_max_addr got %0d exp 9", max_addr); end
  endtask

  task automatic test_reset_mid;
    pulse_start(4'd3);
    repeat (11) @(negedge clk);
    checks += 2;
    if (sif.led !== 4'h8) begin errors++; $display("FAIL rstmid_pre_led got %h exp 8", sif.led); end
    if (sif.busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy got %b exp 1", sif.busy); end
    #2 reset = 1'b1;
    #1;
    checks += 2;
    if (sif.led !== 4'h0) begin errors++; $display("FAIL rstmid_led got %h exp 0", sif.led); end
    if (sif.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", sif.busy); end
    @(negedge clk);
    reset = 1'b0;
    pulse_start(4'd2);
    checks++;
    if (sif.rd_addr !== 4'd0) begin errors++; $display("FAIL rstmid_addr got %0d exp 0", sif.rd_addr); end
    @(negedge clk);
    checks++;
    if (sif.led !== 4'h4) begin errors++; $display("FAIL rstmid_replay_led got %h exp 4", sif.led); end
    repeat (12) @(negedge clk);
  endtask

`ifdef SEQ_PLAYER_ABORT_EN
  task automatic test_abort;
    int dones = 0;
    pulse_start(4'd3);
    repeat (9) @(negedge clk);
    sif.abort = 1'b1;
    @(negedge clk);
    sif.abort = 1'b0;
    checks += 3;
    if (sif.led !== 4'h0) begin errors++; $display("FAIL abort_led got %h exp 0", sif.led); end
    if (sif.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", sif.busy); end
    if (sif.done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", sif.done); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (sif.done === 1'b1 || sif.busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles exp 0", dones); end
    pulse_start(4'd1);
    @(negedge clk);
    checks++;
    if (sif.led !== 4'h4) begin errors++; $display("FAIL abort_replay_led got %h exp 4", sif.led); end
    repeat (4) @(negedge clk);
    checks++;
    if (sif.done !== 1'b1) begin errors++; $display("FAIL abort_replay_done got %b exp 1", sif.done); end
    @(negedge clk);
  endtask
`endif

  initial begin
    rom = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd1, 2'd0, 2'd3, 2'd1, 2'd2,
            2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    sif.start = 1'b0;
    sif.len = 4'd0;
`ifdef SEQ_PLAYER_ABORT_EN
    sif.abort = 1'b0;
`endif
    test_reset();
    test_basic();
    test_len_zero();
    test_clamp();
    test_ignored_start();
    test_reset_mid();
`ifdef SEQ_PLAYER_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
